// File: rtl/bls12_381_fe12_inv_conj_stage_pkg.sv
// Shared BLS12-381 field constants and Fp12 framing definitions for the
// final-exponentiation inverse/conjugate front stage.
package bls12_381_fe12_inv_conj_stage_pkg;

    localparam int DAT_BITS = 381;
    localparam logic [383:0] P_WIDE = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam logic [DAT_BITS-1:0] P = P_WIDE[DAT_BITS-1:0];

    typedef logic [DAT_BITS-1:0] fe_t;

    localparam int FE12_WORDS   = 12;
    localparam int FE12_C1_BASE = 6;

    localparam logic [3:0] FE12_LAST  = 4'(FE12_WORDS - 1);
    localparam logic [3:0] FE12_C1_IX = 4'(FE12_C1_BASE);

    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } conj_state_e;

    // Word counter that wraps back to c0.c0.c0 after the last Fp12 word.
    function automatic logic [3:0] fe12_next(input logic [3:0] k);
        return (k == FE12_LAST) ? 4'd0 : k + 4'd1;
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Generic valid/ready stream bundle with framing, control and error sideband.
interface if_axi_stream #(
    parameter int DAT_BITS = 381,
    parameter int CTL_BITS = 12
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, err, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, err, dat, ctl, output rdy);
endinterface

// File: rtl/bls12_381_fe12_inv_conj_stage.sv
// Easy-part front stage: forwards f to the Fp12 inverter, builds conj(f) via
// the shared subtractor, and pairs f^-1[k] with conj(f)[k] for the multiplier.
module bls12_381_fe12_inv_conj_stage
    import bls12_381_fe12_inv_conj_stage_pkg::*;
#(
    parameter type FE_TYPE     = fe_t,
    parameter int  CTL_BITS    = 12,
    parameter int  OVR_WRT_BIT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    if_axi_stream.sink   i_fe12_if,
    if_axi_stream.source o_inv_fe12_if,
    if_axi_stream.sink   i_inv_fe12_if,
    if_axi_stream.source o_sub_fe_if,
    if_axi_stream.sink   i_sub_fe_if,
    if_axi_stream.source o_mul_fe12_if
);

    conj_state_e           state;
    logic [3:0]            in_cnt;
    logic [3:0]            out_cnt;
    logic [FE12_WORDS-1:0] conj_vld;
    logic                  err_sticky;
    logic [CTL_BITS-1:0]   ctl_cap;
    FE_TYPE                fe_buf [FE12_WORDS];

    logic                  mul_vld_p1;
    logic [2*DAT_BITS-1:0] mul_dat_p1;
    logic                  mul_sop_p1;
    logic                  mul_eop_p1;
    logic                  mul_err_p1;
    logic [CTL_BITS-1:0]   mul_ctl_p1;

    logic                  load_ok;
    logic                  in_c1;
    logic                  in_acc;
    logic                  inv_acc;
    logic                  mul_hs;
    logic                  sub_ret;
    logic [3:0]            sub_idx;
    logic [CTL_BITS-1:0]   sub_ctl;

    // Stage p0: combinational pass-through to inverter and subtractor
    always_comb begin
        load_ok = i_rst && (state == ST_LOAD);
        in_c1   = (in_cnt >= FE12_C1_IX);
        sub_ctl = i_fe12_if.ctl;
        sub_ctl[OVR_WRT_BIT +: 4] = in_cnt;
    end

    assign i_fe12_if.rdy     = load_ok && o_inv_fe12_if.rdy && (!in_c1 || o_sub_fe_if.rdy);

    assign o_inv_fe12_if.val = load_ok && i_fe12_if.val && (!in_c1 || o_sub_fe_if.rdy);
    assign o_inv_fe12_if.dat = i_fe12_if.dat;
    assign o_inv_fe12_if.err = i_fe12_if.err;
    assign o_inv_fe12_if.ctl = i_fe12_if.ctl;
    assign o_inv_fe12_if.sop = (in_cnt == 4'd0);
    assign o_inv_fe12_if.eop = (in_cnt == FE12_LAST);

    // Negation is 0 - x, so the minuend half of the request is zero.
    assign o_sub_fe_if.val   = load_ok && i_fe12_if.val && in_c1 && o_inv_fe12_if.rdy;
    assign o_sub_fe_if.dat   = {i_fe12_if.dat, {DAT_BITS{1'b0}}};
    assign o_sub_fe_if.ctl   = sub_ctl;
    assign o_sub_fe_if.err   = i_fe12_if.err;
    assign o_sub_fe_if.sop   = 1'b1;
    assign o_sub_fe_if.eop   = 1'b1;

    assign i_sub_fe_if.rdy   = 1'b1;

    // The eop beat must leave the output register before the FSM can re-arm.
    assign i_inv_fe12_if.rdy = i_rst && (state == ST_EMIT) && conj_vld[out_cnt] &&
                               !(mul_vld_p1 && mul_eop_p1) &&
                               (!mul_vld_p1 || o_mul_fe12_if.rdy);

    assign in_acc  = i_fe12_if.val && i_fe12_if.rdy;
    assign inv_acc = i_inv_fe12_if.val && i_inv_fe12_if.rdy;
    assign mul_hs  = mul_vld_p1 && o_mul_fe12_if.rdy;
    assign sub_ret = i_sub_fe_if.val && (i_sub_fe_if.ctl[OVR_WRT_BIT +: 4] <= FE12_LAST);
    assign sub_idx = i_sub_fe_if.ctl[OVR_WRT_BIT +: 4];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_LOAD;
            in_cnt     <= 4'd0;
            out_cnt    <= 4'd0;
            conj_vld   <= '0;
            err_sticky <= 1'b0;
            mul_vld_p1 <= 1'b0;
        end else begin
            if (in_acc) begin
                if (!in_c1) conj_vld[in_cnt] <= 1'b1;
                if (i_fe12_if.err) err_sticky <= 1'b1;
                in_cnt <= fe12_next(in_cnt);
                if (in_cnt == FE12_LAST) state <= ST_EMIT;
            end
            if (sub_ret) conj_vld[sub_idx] <= 1'b1;
            if (inv_acc) begin
                mul_vld_p1 <= 1'b1;
                if (i_inv_fe12_if.err) err_sticky <= 1'b1;
                if (out_cnt != FE12_LAST) out_cnt <= out_cnt + 4'd1;
            end else if (mul_hs) begin
                mul_vld_p1 <= 1'b0;
            end
            if (mul_hs && mul_eop_p1) begin
                state      <= ST_LOAD;
                out_cnt    <= 4'd0;
                conj_vld   <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

    // Stage p1: word buffer and registered multiplier output
    always_ff @(posedge i_clk) begin
        if (in_acc && !in_c1) fe_buf[in_cnt] <= i_fe12_if.dat;
        if (sub_ret) fe_buf[sub_idx] <= i_sub_fe_if.dat;
        if (in_acc && in_cnt == 4'd0) ctl_cap <= i_fe12_if.ctl;
        if (inv_acc) begin
            mul_dat_p1 <= {i_inv_fe12_if.dat, fe_buf[out_cnt]};
            mul_sop_p1 <= (out_cnt == 4'd0);
            mul_eop_p1 <= (out_cnt == FE12_LAST);
            mul_err_p1 <= err_sticky | i_inv_fe12_if.err;
            mul_ctl_p1 <= ctl_cap;
        end
    end

    assign o_mul_fe12_if.val = mul_vld_p1;
    assign o_mul_fe12_if.dat = mul_dat_p1;
    assign o_mul_fe12_if.sop = mul_sop_p1;
    assign o_mul_fe12_if.eop = mul_eop_p1;
    assign o_mul_fe12_if.err = mul_err_p1;
    assign o_mul_fe12_if.ctl = mul_ctl_p1;

    logic unused_side;
    assign unused_side = &{1'b0, i_fe12_if.sop, i_fe12_if.eop, i_inv_fe12_if.sop,
                           i_inv_fe12_if.eop, i_inv_fe12_if.ctl, i_sub_fe_if.sop,
                           i_sub_fe_if.eop, i_sub_fe_if.err, i_sub_fe_if.ctl};

endmodule
